// File: rtl/serializer.sv
// Frame-to-word serializer: captures N_SAMPLES words in one handshake, then
// emits them one per handshake on a single-word output, index 0 first.
module serializer #(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIT_WIDTH-1:0] buf_q [N_SAMPLES-1:0];
  logic [BIT_WIDTH-1:0] buf_d [N_SAMPLES-1:0];
  logic                 recv_fire;
  logic                 send_fire;

  // Handshakes: a transfer fires on a side at a posedge where val && rdy are
  // both 1. val never waits on rdy; rdy depends only on state and reset.
  always_comb begin
    recv_rdy  = (state_q == IDLE) && !reset;
    send_val  = (state_q == SEND) && !reset;
    recv_fire = recv_val && recv_rdy;
    send_fire = send_val && send_rdy;
    send_msg  = buf_q[idx_q];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (recv_fire) begin
          for (int i = 0; i < N_SAMPLES; i++) begin
            buf_d[i] = recv_msg[i];
          end
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (send_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < N_SAMPLES; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed N=8/W=32 sequence plus a randomized
// back-to-back run on an N=4/W=8 instance, both checked through scoreboards.
module tb_serializer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N=8, W=32 instance ----------------
  logic        r8_val;
  logic        r8_rdy;
  logic [31:0] r8_msg [7:0];
  logic        s8_val;
  logic        s8_rdy;
  logic [31:0] s8_msg;

  serializer #(.N_SAMPLES(8), .BIT_WIDTH(32)) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .recv_val (r8_val),
    .recv_rdy (r8_rdy),
    .recv_msg (r8_msg),
    .send_val (s8_val),
    .send_rdy (s8_rdy),
    .send_msg (s8_msg)
  );

  // ---------------- N=4, W=8 instance ----------------
  logic       r4_val;
  logic       r4_rdy;
  logic [7:0] r4_msg [3:0];
  logic       s4_val;
  logic       s4_rdy;
  logic [7:0] s4_msg;

  serializer #(.N_SAMPLES(4), .BIT_WIDTH(8)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .recv_val (r4_val),
    .recv_rdy (r4_rdy),
    .recv_msg (r4_msg),
    .send_val (s4_val),
    .send_rdy (s4_rdy),
    .send_msg (s4_msg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  exp4_q[$];
  int tests_run = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push an 8-word frame base+i and drive it for capture at the next posedge.
  task automatic drive_frame8(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      r8_msg[i] = base + 32'(i);
      exp_q.push_back(base + 32'(i));
    end
    r8_val = 1'b1;
  endtask

  // Called at a negedge in SEND: compare the presented word, pop it if it fires.
  task automatic observe8(input string tag);
    check({tag, "_val"}, {31'd0, s8_val}, 32'd1);
    check({tag, "_rdy"}, {31'd0, r8_rdy}, 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_msg"}, s8_msg, exp_q[0]);
      if (s8_rdy) void'(exp_q.pop_front());
    end
  endtask

  task automatic expect_idle8(input string tag, input logic [31:0] exp_msg);
    check({tag, "_rdy"}, {31'd0, r8_rdy}, 32'd1);
    check({tag, "_val"}, {31'd0, s8_val}, 32'd0);
    check({tag, "_msg"}, s8_msg, exp_msg);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          busy;
    int          sent;
    int          frames_in;
    int          cyc;
    logic [31:0] nxt [3:0];

    r8_val = 1'b0;
    s8_rdy = 1'b0;
    r4_val = 1'b0;
    s4_rdy = 1'b0;
    for (int i = 0; i < 8; i++) r8_msg[i] = '0;
    for (int i = 0; i < 4; i++) r4_msg[i] = '0;

    // Reset for two cycles: outputs forced low during reset.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_recv_rdy", {31'd0, r8_rdy}, 32'd0);
      check("rst_send_val", {31'd0, s8_val}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    expect_idle8("post_rst", 32'd0);
    check("post_rst4_rdy", {31'd0, r4_rdy}, 32'd1);
    check("post_rst4_msg", {24'd0, s4_msg}, 32'd0);

    // Basic frame with send_rdy held high.
    s8_rdy = 1'b1;
    drive_frame8(32'h100);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r8_val = 1'b0;
      observe8("basic");
    end
    @(negedge clk);
    expect_idle8("basic_done", 32'h100);
    check("basic_drain", exp_q.size(), 32'd0);

    // Back-pressure: word 2 held for three stalled cycles.
    drive_frame8(32'h100);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      r8_val = 1'b0;
      s8_rdy = !(k >= 2 && k <= 4);
      observe8("bp");
      if (k >= 2 && k <= 4) check("bp_hold", s8_msg, 32'h102);
    end
    s8_rdy = 1'b1;
    @(negedge clk);
    expect_idle8("bp_done", 32'h100);
    check("bp_drain", exp_q.size(), 32'd0);

    // Upstream keeps offering a different frame during SEND.
    drive_frame8(32'h100);
    @(negedge clk);
    for (int i = 0; i < 8; i++) r8_msg[i] = 32'hDEADBEEF;
    observe8("upd_first");
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      observe8("upd");
    end
    @(negedge clk);
    expect_idle8("upd_idle", 32'h100);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hDEADBEEF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r8_val = 1'b0;
      observe8("upd_new");
    end
    @(negedge clk);
    expect_idle8("upd_done", 32'hDEADBEEF);

    // Reset after word 4 has been sent.
    drive_frame8(32'h100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      r8_val = 1'b0;
      observe8("midrst");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_rdy", {31'd0, r8_rdy}, 32'd0);
    check("midrst_val", {31'd0, s8_val}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_idle8("midrst_idle", 32'd0);
    drive_frame8(32'h200);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      r8_val = 1'b0;
      observe8("midrst_new");
    end
    @(negedge clk);
    expect_idle8("midrst_done", 32'h200);

    // Randomized back-to-back frames on the N=4 instance, tracked by a model.
    busy = 1'b0;
    sent = 0;
    frames_in = 0;
    cyc = 0;
    for (int i = 0; i < 4; i++) nxt[i] = 32'($urandom_range(0, 255));
    while ((frames_in < 50 || exp4_q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      check("rnd_excl", {31'd0, r4_rdy && s4_val}, 32'd0);
      check("rnd_rdy", {31'd0, r4_rdy}, {31'd0, !busy});
      check("rnd_val", {31'd0, s4_val}, {31'd0, busy});
      r4_val = (frames_in < 50) && ($urandom_range(0, 9) < 7);
      s4_rdy = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < 4; i++) r4_msg[i] = nxt[i][7:0];
      if (!busy && r4_val) begin
        for (int i = 0; i < 4; i++) begin
          exp4_q.push_back(nxt[i][7:0]);
          nxt[i] = 32'($urandom_range(0, 255));
        end
        frames_in++;
        busy = 1'b1;
        sent = 0;
      end else if (busy && s4_rdy) begin
        if (exp4_q.size() == 0) begin
          check("rnd_underflow", 32'd1, 32'd0);
        end else begin
          check("rnd_msg", {24'd0, s4_msg}, {24'd0, exp4_q.pop_front()});
        end
        sent++;
        if (sent == 4) busy = 1'b0;
      end
    end
    check("rnd_timeout", {31'd0, cyc >= 5000}, 32'd0);
    check("rnd_frames", frames_in, 32'd50);
    check("rnd_drain", exp4_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter that sits directly downstream of the N-sample processing stage (e.g. FFT output), mirroring the deserializer on the input side.
- Accepts one frame of N_SAMPLES words in a single val/rdy handshake, buffers it, then emits the words one per handshake on a single-word val/rdy output, index 0 first.
- Feeds the output SPI/wishbone-facing logic.

Parameters:
- N_SAMPLES, 8, words per frame; power of two, >= 2.
- BIT_WIDTH, 32, width of each word.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- recv_val  input  1  upstream frame valid.
- recv_rdy  output  1  block can accept a frame.
- recv_msg  input  BIT_WIDTH x N_SAMPLES (unpacked array [N_SAMPLES-1:0])  frame words; element i is sample i.
- send_val  output  1  send_msg holds a valid word.
- send_rdy  input  1  downstream accepts the word.
- send_msg  output  BIT_WIDTH  current output word.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All registers update only on posedge clk.
- Internal state:
  - N_SAMPLES x BIT_WIDTH frame buffer.
  - Index counter idx, $clog2(N_SAMPLES) bits.
  - 1-bit FSM, states IDLE and SEND.
- Reset, sampled at a posedge with reset=1:
  - state<=IDLE, idx<=0, all buffer entries <=0.
  - Reset overrides any concurrent handshake.
- While reset is high: recv_rdy=0 and send_val=0, forced combinationally.
- A handshake fires on a side when val&&rdy are both 1 at a posedge.
- IDLE:
  - recv_rdy=1, send_val=0.
  - On recv handshake: all N_SAMPLES words are captured into the buffer, idx<=0, state<=SEND.
  - recv_val=0 leaves the buffer unchanged and stays in IDLE.
- SEND:
  - recv_rdy=0, send_val=1, send_msg=buffer[idx] (combinational mux).
  - On send handshake with idx<N_SAMPLES-1: idx<=idx+1.
  - On send handshake with idx==N_SAMPLES-1: idx<=0, state<=IDLE.
  - With send_rdy=0: idx, buffer and send_msg hold stable; no time-out.
- send_msg when send_val=0 is buffer[idx], a defined value and never X. It is 0 after reset and buffer[0] of the last frame after a completed frame. Consumers must not rely on it.
- Latency: the first word is valid the cycle after the recv handshake. With send_rdy held at 1, words 0..N-1 appear on N consecutive cycles.
- Throughput: one frame per N_SAMPLES+1 cycles at best. recv_rdy is asserted the cycle after the last send handshake; the receive and send phases do not overlap.
- recv_msg changing while in SEND has no effect. Only the captured frame is emitted.
- Reset mid-frame: remaining words are discarded, the next cycle is IDLE, and no partial word is re-sent.
- idx never wraps past N_SAMPLES-1 and never exceeds N_SAMPLES-1.
- recv_rdy and send_val are never 1 in the same cycle.
- recv_rdy depends only on state and reset; there is no combinational path from send_rdy to recv_rdy.

Test Plan:
- Reset then idle (N=8, W=32): reset for 2 cycles, then release -> recv_rdy=0 during reset; afterwards recv_rdy=1, send_val=0, send_msg=0.
- Basic frame: recv_msg[i]=0x100+i, recv_val=1 for one cycle, send_rdy=1 -> on the next 8 cycles send_val=1 with send_msg=0x100..0x107 in order. recv_rdy=0 during those cycles and returns to 1 on the 9th cycle.
- Back-pressure: same frame, send_rdy=0 for 3 cycles after word 2 -> send_msg stays 0x102 with send_val=1; the sequence then resumes at 0x103 with no loss or duplication.
- Upstream changes during SEND: after capturing 0x100..0x107, drive recv_msg to all 0xDEADBEEF with recv_val=1 -> output remains 0x100..0x107. The new frame is captured only in the first IDLE cycle, then emitted.
- Reset mid-frame: assert reset after word 4 is sent -> the next cycle is IDLE with recv_rdy=1 and send_val=0. A following frame 0x200..0x207 is emitted fully from 0x200.
- Back-to-back frames with random send_rdy (N=4, W=8): 50 random frames -> the scoreboard sees every word exactly once and in order, with recv_rdy&&send_val never both 1.
